// File: rtl/diff_pulse_trigger_pkg.sv
// Shared definitions for the delayed-difference pulse trigger.
// Holds the detector FSM state encoding and the lane-index width.
package diff_pulse_trigger_pkg;

   localparam int unsigned LANE_IDX_W = 4;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StArmed   = 2'd1,
      StCapture = 2'd2,
      StHoldoff = 2'd3
   } trig_state_e;

endpackage

// File: rtl/lane_first_hit.sv
// Priority encoder over per-lane hit flags: the lowest lane index is the oldest
// sample in the beat and therefore the leading edge. Purely combinational.
module lane_first_hit
   import diff_pulse_trigger_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS = 16
) (
   input  logic [NUM_CHANNELS-1:0] hits,
   output logic                    any,
   output logic [LANE_IDX_W-1:0]   idx
);

   always_comb begin
      any = |hits;
      idx = '0;
      // Scan from the top so the lowest set lane is the last one written.
      for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
         if (hits[k]) idx = LANE_IDX_W'(k);
      end
   end

endmodule

// File: rtl/diff_pulse_trigger.sv
// Pulse leading-edge detector on the 16-lane delayed-difference stream: timestamps the
// first crossing lane, captures the peak over a window, emits one event, then holds off.
module diff_pulse_trigger
   import diff_pulse_trigger_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS = 16,
   parameter int unsigned DATA_WIDTH   = 20,
   parameter int unsigned TS_WIDTH     = 32
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               enable,
   input  logic [DATA_WIDTH-1:0]              threshold,
   input  logic [7:0]                         peak_win,
   input  logic [15:0]                        holdoff_len,
   input  logic                               valid_in,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] diff_in,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_in,
   output logic                               trig_valid,
   output logic [TS_WIDTH+LANE_IDX_W-1:0]     trig_ts,
   output logic [DATA_WIDTH-1:0]              trig_peak,
   output logic [15:0]                        missed_cnt,
   output logic                               busy
);

   // Lane arithmetic: one extra bit so negating the most negative difference cannot wrap.
   logic [NUM_CHANNELS-1:0]      hit_raw;
   logic signed [DATA_WIDTH-1:0] beat_max;
   logic signed [DATA_WIDTH-1:0] lane_val;
   logic signed [DATA_WIDTH:0]   diff_ext;
   logic signed [DATA_WIDTH:0]   rise;
   logic signed [DATA_WIDTH:0]   thr_ext;

   always_comb begin
      hit_raw  = '0;
      beat_max = $signed(data_in[DATA_WIDTH-1:0]);
      lane_val = '0;
      diff_ext = '0;
      rise     = '0;
      thr_ext  = {threshold[DATA_WIDTH-1], threshold};
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         diff_ext   = {diff_in[k*DATA_WIDTH+DATA_WIDTH-1], diff_in[k*DATA_WIDTH +: DATA_WIDTH]};
         rise       = -diff_ext;
         hit_raw[k] = (rise >= thr_ext);
         lane_val   = data_in[k*DATA_WIDTH +: DATA_WIDTH];
         if (lane_val > beat_max) beat_max = lane_val;
      end
   end

   logic                         v1_q;
   logic [NUM_CHANNELS-1:0]      hit_q;
   logic signed [DATA_WIDTH-1:0] max_q;
   logic [TS_WIDTH-1:0]          beat_q;
   logic [TS_WIDTH-1:0]          beat_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q       <= 1'b0;
         hit_q      <= '0;
         max_q      <= '0;
         beat_q     <= '0;
         beat_cnt_q <= '0;
      end else begin
         v1_q <= valid_in;
         if (valid_in) begin
            hit_q      <= hit_raw;
            max_q      <= beat_max;
            beat_q     <= beat_cnt_q;
            beat_cnt_q <= beat_cnt_q + TS_WIDTH'(1);
         end
      end
   end

   logic                  any_hit;
   logic [LANE_IDX_W-1:0] lead_idx;

   lane_first_hit #(
      .NUM_CHANNELS(NUM_CHANNELS)
   ) u_first_hit (
      .hits(hit_q),
      .any (any_hit),
      .idx (lead_idx)
   );

   trig_state_e                      state_q, state_d, post_event;
   logic [7:0]                       win_q, win_d, pw_eff;
   logic [15:0]                      hold_q, hold_d, missed_q, missed_d, missed_inc;
   logic signed [DATA_WIDTH-1:0]     peak_q, peak_d;
   logic [TS_WIDTH+LANE_IDX_W-1:0]   ts_q, ts_d;
   logic                             ev_q, ev_d;
   logic [8:0]                       win_inc;
   logic [16:0]                      hold_inc;

   assign pw_eff     = (peak_win == 8'd0) ? 8'd1 : peak_win;
   assign win_inc    = {1'b0, win_q} + 9'd1;
   assign hold_inc   = {1'b0, hold_q} + 17'd1;
   assign missed_inc = (missed_q != 16'hFFFF) ? missed_q + 16'd1 : missed_q;
   assign post_event = (holdoff_len == 16'd0) ? StArmed : StHoldoff;

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      hold_d   = hold_q;
      peak_d   = peak_q;
      ts_d     = ts_q;
      missed_d = missed_q;
      ev_d     = 1'b0;
      if (!enable) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: state_d = StArmed;
            StArmed: begin
               if (v1_q && any_hit) begin
                  ts_d   = {beat_q, lead_idx};
                  peak_d = max_q;
                  win_d  = 8'd1;
                  hold_d = '0;
                  if (pw_eff == 8'd1) begin
                     ev_d    = 1'b1;
                     state_d = post_event;
                  end else begin
                     state_d = StCapture;
                  end
               end
            end
            StCapture: begin
               if (v1_q) begin
                  if (any_hit) missed_d = missed_inc;
                  if (max_q > peak_q) peak_d = max_q;
                  win_d = win_inc[7:0];
                  if (win_inc >= {1'b0, pw_eff}) begin
                     ev_d    = 1'b1;
                     hold_d  = '0;
                     state_d = post_event;
                  end
               end
            end
            StHoldoff: begin
               if (v1_q) begin
                  if (any_hit) missed_d = missed_inc;
                  hold_d = hold_inc[15:0];
                  if (hold_inc >= {1'b0, holdoff_len}) state_d = StArmed;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         win_q    <= '0;
         hold_q   <= '0;
         peak_q   <= '0;
         ts_q     <= '0;
         missed_q <= '0;
         ev_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         hold_q   <= hold_d;
         peak_q   <= peak_d;
         ts_q     <= ts_d;
         missed_q <= missed_d;
         ev_q     <= ev_d;
      end
   end

   // Published event fields change only on an event; a retrigger on the same edge
   // overwrites ts_q/peak_q only after they have been read here.
   always_ff @(posedge clk) begin
      if (rst) begin
         trig_valid <= 1'b0;
         trig_ts    <= '0;
         trig_peak  <= '0;
      end else begin
         trig_valid <= ev_q;
         if (ev_q) begin
            trig_ts   <= ts_q;
            trig_peak <= peak_q;
         end
      end
   end

   assign missed_cnt = missed_q;
   assign busy       = (state_q == StCapture) || (state_q == StHoldoff);

endmodule
